// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready command into one SETUP/ACCESS transfer and a one-cycle response.
// Optional ACCESS timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BUS_WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MAX_DIM        = BUS_WIDTH / DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
    input  logic [MAX_DIM-1:0]    cmd_strb_i,
    output logic                  rsp_valid_o,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_slverr_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [MAX_DIM-1:0]    pstrb_o,
    input  logic                  pready_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i,
    input  logic                  pslverr_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [BUS_WIDTH-1:0]  r_pwdata;
    logic [MAX_DIM-1:0]    r_pstrb;
    logic                  r_rsp_valid;
    logic [BUS_WIDTH-1:0]  r_rsp_rdata;
    logic                  r_rsp_slverr;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wait_cnt;
`else
    // Timeout length has no effect when the wait counter is not built.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    assign cmd_ready_o = (r_state == IDLE) && rst_ni;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_pstrb      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            r_wait_cnt   <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Reads drive zero data and strobes onto the bus.
                    if (cmd_valid_i && cmd_ready_o) begin
                        r_pwrite <= cmd_write_i;
                        r_paddr  <= cmd_addr_i;
                        r_pwdata <= cmd_write_i ? cmd_wdata_i : '0;
                        r_pstrb  <= cmd_write_i ? cmd_strb_i : '0;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (pready_i) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_slverr <= pslverr_i;
                        r_rsp_rdata  <= r_pwrite ? '0 : prdata_i;
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_state      <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_slverr <= 1'b1;
                        r_rsp_rdata  <= '0;
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign psel_o       = r_psel;
    assign penable_o    = r_penable;
    assign pwrite_o     = r_pwrite;
    assign paddr_o      = r_paddr;
    assign pwdata_o     = r_pwdata;
    assign pstrb_o      = r_pstrb;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_rdata_o  = r_rsp_rdata;
    assign rsp_slverr_o = r_rsp_slverr;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: vector table of transfers plus back-to-back, reset-abort and timeout sequences.
module tb_apb_master;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [1:0]  cmd_strb;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_slverr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [63:0] pwdata;
    logic [1:0]  pstrb;
    logic        pready;
    logic [63:0] prdata;
    logic        pslverr;

    int checks   = 0;
    int failures = 0;

    apb_master #(
        .DATA_WIDTH(32), .BUS_WIDTH(64), .ADDR_WIDTH(32), .MAX_DIM(2), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_slverr_o(rsp_slverr),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
        .pwdata_o(pwdata), .pstrb_o(pstrb),
        .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [1:0]  strb;
        int          waits;
        logic [63:0] prdata;
        logic        slverr;
        logic [63:0] exp_pwdata;
        logic [1:0]  exp_pstrb;
        logic [63:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one command from IDLE and checks every phase through the response.
    task automatic run_vec(input vec_t v);
        chk("idle_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb;
        step();
        cmd_valid = 1'b0;
        cmd_wdata = 64'h5555_5555_5555_5555; cmd_addr = 32'hFFFF_0000;
        chk("setup_psel", 64'(psel), 64'd1);
        chk("setup_penable", 64'(penable), 64'd0);
        chk("setup_ready", 64'(cmd_ready), 64'd0);
        pready = 1'b1; pslverr = 1'b1; prdata = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        for (int i = 0; i <= v.waits; i++) begin
            chk("access_psel", 64'(psel), 64'd1);
            chk("access_penable", 64'(penable), 64'd1);
            chk("access_pwrite", 64'(pwrite), 64'(v.wr));
            chk("access_paddr", 64'(paddr), 64'(v.addr));
            chk("access_pwdata", pwdata, v.exp_pwdata);
            chk("access_pstrb", 64'(pstrb), 64'(v.exp_pstrb));
            chk("access_no_rsp", 64'(rsp_valid), 64'd0);
            if (i < v.waits) begin
                pready = 1'b0; pslverr = 1'b1; prdata = 64'h0BAD_0BAD_0BAD_0BAD;
            end else begin
                pready = 1'b1; pslverr = v.slverr; prdata = v.prdata;
            end
            step();
        end
        pready = 1'b0; pslverr = 1'b0; prdata = 64'h7777_7777_7777_7777;
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_slverr", 64'(rsp_slverr), 64'(v.slverr));
        chk("rsp_psel_drop", 64'(psel), 64'd0);
        chk("rsp_paddr_hold", 64'(paddr), 64'(v.addr));
        step();
        chk("rsp_pulse_end", 64'(rsp_valid), 64'd0);
        chk("rsp_rdata_hold", rsp_rdata, v.exp_rdata);
    endtask

    vec_t vecs[5];
    int   n_acc;
    int   n_setup;
    int   n_rsp;
    int   last_acc;

    initial begin
        vecs[0] = '{1'b1, 32'h10, 64'h1122334455667788, 2'b11, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                    64'h1122334455667788, 2'b11, 64'h0};
        vecs[1] = '{1'b0, 32'h20, 64'hAAAA_AAAA_AAAA_AAAA, 2'b11, 3, 64'hDEADBEEFCAFEF00D, 1'b0,
                    64'h0, 2'b00, 64'hDEADBEEFCAFEF00D};
        vecs[2] = '{1'b0, 32'h30, 64'h0, 2'b10, 0, 64'h0000_0000_0000_1234, 1'b1,
                    64'h0, 2'b00, 64'h0000_0000_0000_1234};
        vecs[3] = '{1'b1, 32'h40, 64'h0102_0304_0506_0708, 2'b01, 0, 64'h9999, 1'b0,
                    64'h0102_0304_0506_0708, 2'b01, 64'h0};
        vecs[4] = '{1'b1, 32'h48, 64'hCAFE_0000_0000_BEEF, 2'b10, 2, 64'h1, 1'b1,
                    64'hCAFE_0000_0000_BEEF, 2'b10, 64'h0};

        rst_ni = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
        repeat (2) step();
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", pwdata, 64'd0);
        chk("rst_pstrb", 64'(pstrb), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_slverr", 64'(rsp_slverr), 64'd0);
        chk("rst_ready_low", 64'(cmd_ready), 64'd0);
        rst_ni = 1'b1;
        #1;

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // Back-to-back: cmd_valid held high, pready tied high.
        n_acc = 0; n_setup = 0; n_rsp = 0; last_acc = -3;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100;
        cmd_wdata = 64'h1; cmd_strb = 2'b11; pready = 1'b1; pslverr = 1'b0;
        for (int s = 0; s < 10; s++) begin
            if (s == 9) cmd_valid = 1'b0;
            chk("b2b_ready_idle", 64'(cmd_ready), 64'(!psel));
            if (rsp_valid) n_rsp++;
            if (psel && !penable) begin
                chk("b2b_setup_addr", 64'(paddr), 64'(32'h100 + 32'(4 * n_setup)));
                n_setup++;
                cmd_addr = 32'h100 + 32'(4 * n_setup);
            end
            if (cmd_valid && cmd_ready) begin
                chk("b2b_interval", 64'(s - last_acc), 64'd3);
                last_acc = s;
                n_acc++;
            end
            step();
        end
        chk("b2b_accepts", 64'(n_acc), 64'd3);
        chk("b2b_setups", 64'(n_setup), 64'd3);
        chk("b2b_rsps", 64'(n_rsp), 64'd3);
        pready = 1'b0;
        step();

        // Reset for one cycle while waiting in ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60;
        step();
        cmd_valid = 1'b0;
        step();
        chk("abort_in_access", 64'(penable), 64'd1);
        step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        #1;
        chk("abort_psel", 64'(psel), 64'd0);
        chk("abort_penable", 64'(penable), 64'd0);
        chk("abort_ready", 64'(cmd_ready), 64'd1);
        chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
        pready = 1'b1; prdata = 64'h4444;
        step();
        chk("abort_no_rsp_late", 64'(rsp_valid), 64'd0);
        chk("abort_idle_psel", 64'(psel), 64'd0);
        pready = 1'b0;

`ifdef APB_MASTER_TIMEOUT_EN
        // Leave a non-zero rdata so the timeout's zero response is visible.
        run_vec(vecs[1]);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h70;
        step();
        cmd_valid = 1'b0; prdata = 64'h3333_3333;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("to_access_held", 64'(penable), 64'd1);
            chk("to_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end
        chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("to_rsp_slverr", 64'(rsp_slverr), 64'd1);
        chk("to_rsp_rdata", rsp_rdata, 64'd0);
        chk("to_psel_drop", 64'(psel), 64'd0);
        step();
        chk("to_pulse_end", 64'(rsp_valid), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
